// File: rtl/sm_uart_rx.sv
// 8N1 serial byte receiver with a mid-bit sampler and a one-entry valid/ready output register.
// Define SM_UART_RX_PARITY_EN to add one even-parity bit between the data bits and the stop bit.
module sm_uart_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef SM_UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_RELOAD = 16'(CLKS_PER_BIT - 1);

`ifdef SM_UART_RX_PARITY_EN
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction
`endif

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   rxs_s;

   state_t      state_r, state_next_s;
   logic [15:0] cnt_r, cnt_next_s;
   logic [2:0]  idx_r, idx_next_s;
   logic [7:0]  shift_r, shift_next_s;
   logic        armed_r, armed_next_s;
   logic        complete_s;
   logic        ferr_s;
`ifdef SM_UART_RX_PARITY_EN
   logic        par_err_r, par_err_next_s;
`endif

   logic [7:0]  rx_data_r;
   logic        rx_valid_r;
   logic        frame_err_r;
   logic        overrun_r;
   logic        busy_r;

   assign rxs_s = sync_r[SYNC_STAGES-1];

   // Input synchroniser; all stages reset to the idle (high) line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], uart_rx};
      end
   end

   // Frame state register: state, baud counter, bit index, shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 16'd0;
         idx_r     <= 3'd0;
         shift_r   <= 8'd0;
         armed_r   <= 1'b0;
`ifdef SM_UART_RX_PARITY_EN
         par_err_r <= 1'b0;
`endif
      end else begin
         state_r   <= state_next_s;
         cnt_r     <= cnt_next_s;
         idx_r     <= idx_next_s;
         shift_r   <= shift_next_s;
         armed_r   <= armed_next_s;
`ifdef SM_UART_RX_PARITY_EN
         par_err_r <= par_err_next_s;
`endif
      end
   end

   // Next-state logic; armed_r blocks a new start until the line has been seen high (break guard).
   always_comb begin
      state_next_s   = state_r;
      cnt_next_s     = cnt_r;
      idx_next_s     = idx_r;
      shift_next_s   = shift_r;
      armed_next_s   = armed_r;
      complete_s     = 1'b0;
      ferr_s         = 1'b0;
`ifdef SM_UART_RX_PARITY_EN
      par_err_next_s = par_err_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (rxs_s) begin
               armed_next_s = 1'b1;
            end else if (armed_r) begin
               state_next_s = ST_START;
               cnt_next_s   = HALF_RELOAD;
            end else begin
               armed_next_s = 1'b0;
            end
         end
         ST_START: begin
            if (cnt_r != 16'd0) begin
               cnt_next_s = cnt_r - 16'd1;
            end else if (!rxs_s) begin
               state_next_s = ST_DATA;
               idx_next_s   = 3'd0;
               cnt_next_s   = FULL_RELOAD;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (cnt_r != 16'd0) begin
               cnt_next_s = cnt_r - 16'd1;
            end else begin
               shift_next_s[idx_r] = rxs_s;
               cnt_next_s          = FULL_RELOAD;
               if (idx_r == 3'd7) begin
                  idx_next_s = 3'd0;
`ifdef SM_UART_RX_PARITY_EN
                  state_next_s = ST_PARITY;
`else
                  state_next_s = ST_STOP;
`endif
               end else begin
                  idx_next_s = idx_r + 3'd1;
               end
            end
         end
`ifdef SM_UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt_r != 16'd0) begin
               cnt_next_s = cnt_r - 16'd1;
            end else begin
               par_err_next_s = (rxs_s != even_parity(shift_r));
               cnt_next_s     = FULL_RELOAD;
               state_next_s   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_r != 16'd0) begin
               cnt_next_s = cnt_r - 16'd1;
            end else begin
               state_next_s = ST_IDLE;
               if (!rxs_s) begin
                  ferr_s       = 1'b1;
                  armed_next_s = 1'b0;
`ifdef SM_UART_RX_PARITY_EN
               end else if (par_err_r) begin
                  ferr_s = 1'b1;
`endif
               end else begin
                  complete_s = 1'b1;
               end
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            cnt_next_s   = 16'd0;
            idx_next_s   = 3'd0;
         end
      endcase
   end

   // Output register: new byte beats a same-cycle handshake; overrun is sticky until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data_r   <= 8'd0;
         rx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         frame_err_r <= ferr_s;
         busy_r      <= (state_next_s != ST_IDLE);
         if (complete_s) begin
            rx_data_r  <= shift_r;
            rx_valid_r <= 1'b1;
            if (rx_valid_r && !rx_ready) begin
               overrun_r <= 1'b1;
            end
         end else if (rx_valid_r && rx_ready) begin
            rx_valid_r <= 1'b0;
         end
      end
   end

   assign rx_data   = rx_data_r;
   assign rx_valid  = rx_valid_r;
   assign frame_err = frame_err_r;
   assign overrun   = overrun_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_sm_uart_rx.sv
// Self-checking bench for sm_uart_rx: vector table, hand-written corner sequences and a
// randomized frame stream checked against a byte-queue model of the serial protocol.
module tb_sm_uart_rx;

   localparam int C = 16;
   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   sm_uart_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .uart_rx   (uart_rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [7:0] got_q[$];
   int rd = 0;
   int fe_cnt = 0;
   int valid_cycles = 0;
`ifdef SM_UART_RX_PARITY_EN
   logic par_bad_g = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_bytes;
      int         exp_ferr;
   } vec_t;

   // Monitor: accepted bytes, frame_err cycles and rx_valid cycles, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) got_q.push_back(rx_data);
         if (frame_err) fe_cnt++;
         if (rx_valid) valid_cycles++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_byte(input string name, input logic [7:0] exp);
      chk({name, "_present"}, 32'(got_q.size() > rd), 32'd1);
      if (got_q.size() > rd) begin
         chk(name, 32'(got_q[rd]), 32'(exp));
         rd++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bit_time(input logic v);
      uart_rx = v;
      repeat (C) tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef SM_UART_RX_PARITY_EN
      bit_time((^d) ^ par_bad_g);
`endif
      bit_time(stop_bit);
      uart_rx = 1'b1;
   endtask

   initial begin
      vec_t tbl[6];
      logic [7:0] model_q[$];
      int fe0, sz0, vc0, lat, n, fe_exp;
      logic [7:0] d;
      logic err;

      tbl[0] = '{data: 8'h00, stop: 1'b1, exp_bytes: 1, exp_ferr: 0};
      tbl[1] = '{data: 8'hFF, stop: 1'b1, exp_bytes: 1, exp_ferr: 0};
      tbl[2] = '{data: 8'h55, stop: 1'b0, exp_bytes: 0, exp_ferr: 1};
      tbl[3] = '{data: 8'h12, stop: 1'b1, exp_bytes: 1, exp_ferr: 0};
      tbl[4] = '{data: 8'h80, stop: 1'b1, exp_bytes: 1, exp_ferr: 0};
      tbl[5] = '{data: 8'h01, stop: 1'b1, exp_bytes: 1, exp_ferr: 0};

      rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0;
      repeat (3) tick();
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (4) tick();

      // Test 1: single 0xA5 with latency measurement
      rx_ready = 1'b1;
      vc0 = valid_cycles; fe0 = fe_cnt;
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (!rx_valid && lat < 400) begin
               tick();
               lat++;
            end
         end
      join
      repeat (C) tick();
      chk("t1_latency_window", 32'(lat >= (19 * C) / 2 + S && lat <= (19 * C) / 2 + S + 2), 32'd1);
      expect_byte("t1_data", 8'hA5);
      chk("t1_valid_cycles", 32'(valid_cycles - vc0), 32'd1);
      chk("t1_frame_err", 32'(fe_cnt - fe0), 32'd0);
      chk("t1_overrun", 32'(overrun), 32'd0);
      rd = got_q.size();

      // Vector table, rx_ready held high
      for (int i = 0; i < 6; i++) begin
         fe0 = fe_cnt; sz0 = got_q.size();
         send_frame(tbl[i].data, tbl[i].stop);
         repeat (C) tick();
         chk($sformatf("vec%0d_bytes", i), 32'(got_q.size() - sz0), 32'(tbl[i].exp_bytes));
         chk($sformatf("vec%0d_ferr_cycles", i), 32'(fe_cnt - fe0), 32'(tbl[i].exp_ferr));
         if (tbl[i].exp_bytes == 1) expect_byte($sformatf("vec%0d_data", i), tbl[i].data);
         rd = got_q.size();
      end

      // Test 3 + break: stop bit low then line held low, no repeated frames
      fe0 = fe_cnt; sz0 = got_q.size();
      send_frame(8'h55, 1'b0);
      uart_rx = 1'b0;
      repeat (4 * C) tick();
      chk("brk_ferr_cycles", 32'(fe_cnt - fe0), 32'd1);
      chk("brk_no_byte", 32'(got_q.size() - sz0), 32'd0);
      chk("brk_not_busy", 32'(busy), 32'd0);
      uart_rx = 1'b1;
      repeat (2 * C) tick();
      send_frame(8'h12, 1'b1);
      repeat (C) tick();
      expect_byte("brk_after_data", 8'h12);
      rd = got_q.size();

      // Test 2: three back-to-back frames with nobody consuming
      rx_ready = 1'b0;
      sz0 = got_q.size();
      send_frame(8'h3C, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h00, 1'b1);
      repeat (C) tick();
      chk("t2_valid", 32'(rx_valid), 32'd1);
      chk("t2_data", 32'(rx_data), 32'h00);
      chk("t2_overrun", 32'(overrun), 32'd1);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      tick();
      chk("t2_valid_cleared", 32'(rx_valid), 32'd0);
      chk("t2_one_handshake", 32'(got_q.size() - sz0), 32'd1);
      expect_byte("t2_consumed", 8'h00);
      rd = got_q.size();

      // Test 4: short low glitch on idle line
      rx_ready = 1'b1;
      fe0 = fe_cnt; vc0 = valid_cycles;
      uart_rx = 1'b0;
      repeat (C / 4) tick();
      uart_rx = 1'b1;
      chk("t4_busy_rose", 32'(busy), 32'd1);
      n = 0;
      while (busy && n < C) begin
         tick();
         n++;
      end
      chk("t4_busy_dropped", 32'(busy), 32'd0);
      repeat (C) tick();
      chk("t4_no_valid", 32'(valid_cycles - vc0), 32'd0);
      chk("t4_no_ferr", 32'(fe_cnt - fe0), 32'd0);

      // Randomized stream against a byte-queue model (good frames queue, bad ones count)
      fe0 = fe_cnt; rd = got_q.size(); fe_exp = 0;
      for (int k = 0; k < 24; k++) begin
         d = 8'($urandom);
         err = ($urandom_range(0, 5) == 0);
         send_frame(d, !err);
         if (err) begin
            fe_exp++;
            repeat (C + $urandom_range(0, C)) tick();
         end else begin
            model_q.push_back(d);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, C)) tick();
         end
      end
      repeat (2 * C) tick();
      chk("rand_count", 32'(got_q.size() - rd), 32'(model_q.size()));
      chk("rand_ferr", 32'(fe_cnt - fe0), 32'(fe_exp));
      foreach (model_q[j]) expect_byte($sformatf("rand%0d", j), model_q[j]);
      rd = got_q.size();

      // Test 5: reset in the middle of bit 4 while a byte is pending
      rx_ready = 1'b0;
      send_frame(8'h5A, 1'b1);
      repeat (C) tick();
      chk("t5_pre_valid", 32'(rx_valid), 32'd1);
      d = 8'h81;
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(d[i]);
      uart_rx = d[4];
      repeat (C / 2) tick();
      rst = 1'b1;
      #1;
      chk("t5_rst_data", 32'(rx_data), 32'd0);
      chk("t5_rst_valid", 32'(rx_valid), 32'd0);
      chk("t5_rst_ferr", 32'(frame_err), 32'd0);
      chk("t5_rst_overrun", 32'(overrun), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      uart_rx = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (C) tick();
      rx_ready = 1'b1;
      rd = got_q.size();
      send_frame(8'h7E, 1'b1);
      repeat (C) tick();
      expect_byte("t5_after_data", 8'h7E);
      chk("t5_after_overrun", 32'(overrun), 32'd0);
      rd = got_q.size();

`ifdef SM_UART_RX_PARITY_EN
      // Test 6: even parity check
      fe0 = fe_cnt; sz0 = got_q.size();
      par_bad_g = 1'b1;
      send_frame(8'h07, 1'b1);
      repeat (C) tick();
      chk("t6_bad_par_ferr", 32'(fe_cnt - fe0), 32'd1);
      chk("t6_bad_par_no_byte", 32'(got_q.size() - sz0), 32'd0);
      par_bad_g = 1'b0;
      send_frame(8'h07, 1'b1);
      repeat (C) tick();
      expect_byte("t6_good_par_data", 8'h07);
      rd = got_q.size();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sm_uart_rx.md
Name: sm_uart_rx

Overview:
- Serial byte receiver that sits directly upstream of the UART ROM loader.
- Synchronises the raw `uart_rx` pin, detects start bits, samples 8N1 frames at mid-bit, and checks the stop bit.
- Holds each received byte in a one-entry output register with a valid/ready handshake.
- The loader consumes these bytes to assemble 32-bit instruction words while ROM-write mode is latched.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range 4..65535.
- SYNC_STAGES, 2, flip-flop stages in the rx input synchroniser; legal range 2..4.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- uart_rx  input  1  raw serial line, idle high, asynchronous to clk.
- rx_data  output  8  received byte, LSB first on the wire.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a byte completed while rx_valid was still high; cleared only by rst.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous and immediate:
  - State goes to IDLE; bit counter and baud counter go to 0.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - All synchroniser stages are set to 1 (line idle).
- Reset mid-frame aborts the frame; no partial byte is ever emitted.
- Synchroniser: uart_rx passes through SYNC_STAGES flops. "rxs" below is the last stage.
- States:
  - IDLE → START on rxs == 0. Load baud counter with CLKS_PER_BIT/2 − 1 (integer division).
  - START: count down to 0, then resample rxs.
    - rxs == 0 → DATA, bit index = 0, baud counter = CLKS_PER_BIT − 1.
    - rxs == 1 (glitch) → IDLE; no outputs change.
  - DATA: each time the counter reaches 0, shift rxs into bit [index] of the shift register and reload the counter.
    - After index 7 → STOP (or PARITY when enabled).
  - STOP: at counter 0, sample rxs.
    - 1 → byte complete.
    - 0 → frame_err pulses for exactly one cycle, byte discarded, → IDLE.
  - After STOP: if rxs == 0, re-enter START only once rxs has first been seen high. This means a held-low line (break) does not produce repeated frames.
- Sampling points: mid-bit. Start bit is confirmed CLKS_PER_BIT/2 cycles after the falling edge is seen at rxs; each data bit is sampled CLKS_PER_BIT cycles after the previous sample.
- Byte complete:
  - On the cycle after the stop sample, rx_data ← shift register and rx_valid ← 1.
  - If rx_valid was already 1 and not being consumed that same cycle: overrun ← 1 and rx_data is overwritten with the newer byte.
- Handshake:
  - rx_valid && rx_ready in a cycle clears rx_valid on the next edge.
  - Completion and consumption in the same cycle: the new byte wins; rx_valid stays 1 and no overrun is flagged.
  - rx_data is stable while rx_valid is 1, except on overrun.
- Latency: rx_valid rises 9.5·CLKS_PER_BIT + SYNC_STAGES + 1 cycles (±1) after the start-bit falling edge at uart_rx.
- Back-to-back frames (stop bit immediately followed by start bit) must all be received with no loss.

Optional Feature:
- Macro: SM_UART_RX_PARITY_EN.
- With the macro defined:
  - A PARITY state follows DATA and samples one even-parity bit.
  - A parity mismatch drives frame_err for one cycle and discards the byte; the stop bit is still sampled before returning to IDLE.
- Without the macro: 8N1 only; the PARITY state and its logic are absent.

Test Plan:
- Test 1: CLKS_PER_BIT=16. Send 0xA5 (8N1) with rx_ready=1 → one rx_valid cycle with rx_data=0xA5; frame_err=0; overrun=0.
- Test 2: Send 0x3C, 0xFF, 0x00 back-to-back with rx_ready=0, then raise rx_ready → overrun=1 and rx_data=0x00; a single handshake clears rx_valid.
- Test 3: Send a frame with stop bit = 0 (data 0x55) → frame_err pulses for 1 cycle, rx_valid stays 0, and a following 0x12 is received correctly.
- Test 4: Drive a 0-pulse of CLKS_PER_BIT/4 cycles on an idle line → no rx_valid and no frame_err; busy returns to 0 within CLKS_PER_BIT cycles.
- Test 5: Assert rst at bit 4 of a frame carrying 0x81 → all outputs 0 immediately; after release, 0x7E is received correctly.
- Test 6: With SM_UART_RX_PARITY_EN defined, send 0x07 with odd-wrong parity → frame_err pulses and no rx_valid; with correct parity, rx_data=0x07.
